// File: rtl/instr_prefetch_buf.sv
`default_nettype none
// =============================================================================
// Module   : instr_prefetch_buf
// Brief    : DEPTH-entry instruction prefetch queue feeding if_id, with
//            back-to-back bus fetches and flush-safe draining of in-flight reads.
// Revision : 1.0 - initial release
// =============================================================================
module instr_prefetch_buf #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     bus_req_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    input  logic                     bus_ready_i,
    input  logic [DATA_W-1:0]        bus_data_i,
    input  logic                     hold_i,
    input  logic                     jump_i,
    input  logic [ADDR_W-1:0]        jump_addr_i,
    input  logic                     jtag_reset_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [DATA_W-1:0]        instr_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [ADDR_W-1:0]        pc_next_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                  c_PTR_W     = $clog2(DEPTH);
    localparam int                  c_CNT_W     = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0]   c_PC_STEP   = ADDR_W'(4);
    localparam logic [c_CNT_W:0]    c_DEPTH_OCC = (c_CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               r_pending;
    logic               r_discard;
    logic [DATA_W-1:0]  r_instr_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_redirect;
    logic [ADDR_W-1:0]  w_target;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_busy_next;
    logic               w_discard_next;
    logic               w_issue;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_CNT_W:0]   w_occ_next;
    logic [ADDR_W-1:0]  w_fetch_pc_next;

    assign w_redirect = jump_i | jtag_reset_i;
    assign w_target   = jtag_reset_i ? RESET_PC : jump_addr_i;
    assign w_resp     = r_pending & bus_ready_i;
    // Responses are dropped if flagged stale or if a redirect lands on them.
    assign w_push     = w_resp & ~r_discard & ~w_redirect;
    assign w_pop      = valid_o & ready_i & ~w_redirect;

    always_comb begin
        w_count_next = r_count;
        if (w_redirect) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (w_redirect) begin
            w_fetch_pc_next = w_target;
        end else if (w_push) begin
            w_fetch_pc_next = r_req_addr + c_PC_STEP;
        end
    end

    // An in-flight fetch reserves a slot, so a completing push can never overflow.
    assign w_busy_next    = r_pending & ~bus_ready_i;
    assign w_discard_next = w_busy_next & (r_discard | w_redirect);
    assign w_occ_next     = {1'b0, w_count_next} + {{c_CNT_W{1'b0}}, w_busy_next};
    assign w_issue        = ~w_busy_next & ~hold_i & (w_occ_next < c_DEPTH_OCC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_discard  <= w_discard_next;
            r_count    <= w_count_next;
            if (w_issue) begin
                r_pending  <= 1'b1;
                r_req_addr <= w_fetch_pc_next;
            end else if (w_resp) begin
                r_pending  <= 1'b0;
            end
            if (w_redirect) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus_data_i;
            r_pc_mem[r_wr_ptr]    <= r_req_addr;
        end
    end

    assign bus_req_o  = r_pending;
    assign bus_addr_o = r_req_addr;
    assign count_o    = r_count;
    assign valid_o    = (r_count != '0);

    // Head fields read as zero while empty so reset and flush present clean values.
    assign instr_o    = valid_o ? r_instr_mem[r_rd_ptr] : '0;
    assign pc_o       = valid_o ? r_pc_mem[r_rd_ptr] : '0;
    assign pc_next_o  = valid_o ? (r_pc_mem[r_rd_ptr] + c_PC_STEP) : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buf.sv
`default_nettype none
// Bench for instr_prefetch_buf: directed + random stimulus, queue-based reference
// of fetch/flush behaviour, and a scoreboard monitor checking every cycle.
module tb_instr_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ready_i = 1'b0;
    logic [31:0] bus_data_i = '0;
    logic        hold_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        jtag_reset_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    instr_prefetch_buf #(
        .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_ready_i(bus_ready_i), .bus_data_i(bus_data_i),
        .hold_i(hold_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .jtag_reset_i(jtag_reset_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_next_o(pc_next_o), .count_o(count_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference: the queue of instructions the consumer should still see,
    // plus the single outstanding bus request and whether it has gone stale.
    entry_t      exp_q[$];
    logic        m_pend = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_fetch = RESET_PC;
    logic        m_after_rst = 1'b0;
    logic        live = 1'b0;
    logic        redir, resp, busy;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference update on each rising edge (inputs are stable since posedge+1).
    initial forever begin
        @(posedge clk);
        if (rst_i) begin
            exp_q.delete();
            m_pend      = 1'b0;
            m_stale     = 1'b0;
            m_fetch     = RESET_PC;
            m_after_rst = 1'b1;
            live        = 1'b1;
        end else if (live) begin
            m_after_rst = 1'b0;
            redir = jump_i || jtag_reset_i;
            resp  = m_pend && bus_ready_i;
            if (redir) begin
                exp_q.delete();
                m_fetch = jtag_reset_i ? RESET_PC : jump_addr_i;
            end else if (resp && !m_stale) begin
                exp_q.push_back('{m_addr, mem_word(m_addr)});
                m_fetch = m_addr + 32'd4;
            end
            busy    = m_pend && !bus_ready_i;
            m_stale = busy && (m_stale || redir);
            if (!busy) begin
                if (!hold_i && exp_q.size() < DEPTH) begin
                    m_pend = 1'b1;
                    m_addr = m_fetch;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: compares every cycle, pops on an effective handshake.
    initial forever begin
        logic [31:0] e_pcn;
        @(negedge clk);
        if (live) begin
            chk("bus_req", bus_req_o, m_pend);
            if (m_pend) chk("bus_addr", bus_addr_o, m_addr);
            chk("valid", valid_o, exp_q.size() != 0);
            chk("count", count_o, exp_q.size());
            if (m_after_rst) begin
                chk("rst_instr", instr_o, 0);
                chk("rst_pc", pc_o, 0);
                chk("rst_pc_next", pc_next_o, 0);
            end
            if (exp_q.size() != 0) begin
                e_pcn = exp_q[0].pc + 32'd4;
                chk("head_pc", pc_o, exp_q[0].pc);
                chk("head_instr", instr_o, exp_q[0].instr);
                chk("head_pc_next", pc_next_o, e_pcn);
                if (ready_i && !jump_i && !jtag_reset_i && !rst_i)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit br, input bit rd, input bit hd,
                         input bit jp, input logic [31:0] ja, input bit jt);
        bus_ready_i  = br && bus_req_o;
        bus_data_i   = mem_word(bus_addr_o);
        ready_i      = rd;
        hold_i       = hd;
        jump_i       = jp;
        jump_addr_i  = ja;
        jtag_reset_i = jt;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic rnd(input int pb, input int pr, input int ph, input int pj, input int pt);
        logic [31:0] ja;
        ja = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        drive(pct(pb), pct(pr), pct(ph), pct(pj), ja, pct(pt));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        // Streaming with bus and consumer always ready.
        repeat (10) drive(1, 1, 0, 0, 0, 0);
        // Fill to DEPTH, single pop, then stay full.
        repeat (8) drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        // Stalled fetch with a jump during the stall.
        drive(0, 1, 0, 1, 32'h100, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        // Jump coinciding with a pop and a bus response.
        drive(1, 1, 0, 1, 32'h300, 0);
        repeat (4) drive(1, 1, 0, 0, 0, 0);
        // JTAG reset wins over a simultaneous jump.
        drive(1, 0, 0, 1, 32'h200, 1);
        repeat (4) drive(1, 1, 0, 0, 0, 0);
        // Address wrap at the top of the address space.
        drive(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        // Reset in mid-stream with a response arriving.
        rst_i = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        rst_i = 1'b0;
        repeat (5) drive(1, 1, 0, 0, 0, 0);
        // Hold-heavy traffic, then general random traffic.
        repeat (40) rnd(70, 50, 60, 0, 0);
        repeat (1500) rnd(60, 60, 20, 5, 2);
        repeat (2) drive(1, 1, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
